// File: rtl/piano_tone_gen.sv
// Multi-key square-wave tone generator: per-key synchroniser and debouncer, fixed-priority
// key select, runtime note table with octave shift, and a glitch-free beep FSM.
module piano_tone_gen #(
    parameter int unsigned NUM_KEYS = 8,
    parameter int unsigned CNT_W    = 14,
    parameter int unsigned DEB_CYC  = 50000,
    localparam int unsigned KW      = $clog2(NUM_KEYS)
) (
    input  logic                clk_5MHz,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [1:0]          octave,
    input  logic                cfg_we,
    input  logic [KW-1:0]       cfg_addr,
    input  logic [CNT_W-1:0]    cfg_data,
    output logic                beep,
    output logic                note_valid,
    output logic [KW-1:0]       note_idx
);

    localparam int unsigned DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DW-1:0] DebMax = DW'(DEB_CYC - 1);

    typedef enum logic [1:0] {StIdle, StPlay, StRelease} state_e;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] key_db_q, key_db_d;
    logic [DW-1:0]       deb_cnt_q [NUM_KEYS];
    logic [DW-1:0]       deb_cnt_d [NUM_KEYS];
    logic [CNT_W-1:0]    tbl_q [NUM_KEYS];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic             beep_q, beep_d;
    logic [KW-1:0]    idx_q, idx_d;

    logic [KW-1:0]    sel;
    logic [CNT_W-1:0] tbl_sel, shifted, h_new;
    logic             sel_valid, at_end;

    // Debounce: a bit flips only after the synced level disagrees for DEB_CYC consecutive cycles.
    always_comb begin
        key_db_d = key_db_q;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            if (sync2_q[k] == key_db_q[k]) begin
                deb_cnt_d[k] = '0;
            end else if (deb_cnt_q[k] == DebMax) begin
                deb_cnt_d[k] = '0;
                key_db_d[k]  = sync2_q[k];
            end else begin
                deb_cnt_d[k] = deb_cnt_q[k] + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_5MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            key_db_q <= '0;
            for (int k = 0; k < int'(NUM_KEYS); k++) begin
                deb_cnt_q[k] <= '0;
                tbl_q[k]     <= '0;
            end
        end else begin
            sync1_q  <= key_in;
            sync2_q  <= sync1_q;
            key_db_q <= key_db_d;
            for (int k = 0; k < int'(NUM_KEYS); k++) begin
                deb_cnt_q[k] <= deb_cnt_d[k];
                if (cfg_we && cfg_addr == KW'(k)) begin
                    tbl_q[k] <= cfg_data;
                end
            end
        end
    end

    // Lowest set index wins; its table entry is muxed out in the same loop.
    always_comb begin
        sel     = '0;
        tbl_sel = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (key_db_q[i]) begin
                sel     = KW'(i);
                tbl_sel = tbl_q[i];
            end
        end
        sel_valid = (|key_db_q) && (tbl_sel != '0);
        shifted   = tbl_sel >> octave;
        h_new     = (shifted < CNT_W'(2)) ? CNT_W'(2) : shifted;
        at_end    = (cnt_q == h_q - CNT_W'(1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        beep_d  = beep_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                beep_d = 1'b0;
                cnt_d  = '0;
                if (sel_valid) begin
                    state_d = StPlay;
                    beep_d  = 1'b1;
                    h_d     = h_new;
                    idx_d   = sel;
                end
            end
            StPlay: begin
                if (!sel_valid) begin
                    // A high pulse in progress always runs to its full latched length.
                    if (!beep_q || at_end) begin
                        state_d = StIdle;
                        beep_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = StRelease;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else if (sel != idx_q) begin
                    cnt_d = '0;
                    h_d   = h_new;
                    idx_d = sel;
                end else if (at_end) begin
                    beep_d = ~beep_q;
                    cnt_d  = '0;
                    h_d    = h_new;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRelease: begin
                if (sel_valid) begin
                    state_d = StPlay;
                    cnt_d   = '0;
                    h_d     = h_new;
                    idx_d   = sel;
                end else if (at_end) begin
                    state_d = StIdle;
                    beep_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                beep_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_5MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            h_q     <= '0;
            beep_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            beep_q  <= beep_d;
            idx_q   <= idx_d;
        end
    end

    assign beep       = beep_q;
    assign note_valid = (state_q == StPlay);
    assign note_idx   = idx_q;

endmodule

// File: tb/tb_piano_tone_gen.sv
// Randomised bench for piano_tone_gen against a countdown-based reference model of the tone.
module tb_piano_tone_gen;

    localparam int NK = 4;
    localparam int CW = 14;
    localparam int DC = 4;

    logic          clk_5MHz = 1'b0;
    logic          rst_n    = 1'b1;
    logic [NK-1:0] key_in   = '0;
    logic [1:0]    octave   = '0;
    logic          cfg_we   = 1'b0;
    logic [1:0]    cfg_addr = '0;
    logic [CW-1:0] cfg_data = '0;
    logic          beep, note_valid;
    logic [1:0]    note_idx;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit [NK-1:0] m_s1, m_s2, m_db;
    int          m_run [NK];
    int          m_tbl [NK];
    bit          m_sounding, m_active, m_beep;
    int          m_left, m_idx;

    piano_tone_gen #(
        .NUM_KEYS (NK),
        .CNT_W    (CW),
        .DEB_CYC  (DC)
    ) dut (
        .clk_5MHz   (clk_5MHz),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .octave     (octave),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .beep       (beep),
        .note_valid (note_valid),
        .note_idx   (note_idx)
    );

    always #5 clk_5MHz = ~clk_5MHz;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0;
        for (int k = 0; k < NK; k++) begin
            m_run[k] = 0;
            m_tbl[k] = 0;
        end
        m_sounding = 0; m_active = 0; m_beep = 0; m_left = 0; m_idx = 0;
    endtask

    // One rising edge: all decisions use the values held just before the edge.
    task automatic model_step();
        int  sel;
        bit  valid;
        int  hn;
        sel = -1;
        for (int k = NK - 1; k >= 0; k--) if (m_db[k]) sel = k;
        valid = (sel >= 0) && (m_tbl[sel] != 0);
        hn = valid ? (m_tbl[sel] >> octave) : 0;
        if (hn < 2) hn = 2;

        if (!m_sounding) begin
            if (valid) begin
                m_sounding = 1; m_active = 1; m_beep = 1; m_left = hn; m_idx = sel;
            end
        end else if (m_active) begin
            if (!valid) begin
                m_active = 0;
                if (!m_beep) m_sounding = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin m_beep = 0; m_sounding = 0; end
                end
            end else if (sel != m_idx) begin
                m_idx = sel; m_left = hn;
            end else begin
                m_left--;
                if (m_left == 0) begin m_beep = !m_beep; m_left = hn; end
            end
        end else begin
            if (valid) begin
                m_active = 1; m_idx = sel; m_left = hn;
            end else begin
                m_left--;
                if (m_left == 0) begin m_beep = 0; m_sounding = 0; end
            end
        end

        if (cfg_we) m_tbl[cfg_addr] = int'(cfg_data);

        for (int k = 0; k < NK; k++) begin
            if (m_s2[k] != m_db[k]) begin
                m_run[k]++;
                if (m_run[k] == DC) begin
                    m_db[k]  = m_s2[k];
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = key_in;
    endtask

    task automatic tick();
        @(posedge clk_5MHz);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check("beep", int'(beep), int'(m_beep));
        check("note_valid", int'(note_valid), int'(m_active));
        check("note_idx", int'(note_idx), m_idx);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_tbl(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = 2'(addr);
        cfg_data = CW'(data);
        tick();
        cfg_we   = 1'b0;
    endtask

    initial begin
        int n;
        int tb_vals [NK] = '{10, 20, 3, 0};

        #1 rst_n = 1'b0;
        #1;
        check("rst_beep", int'(beep), 0);
        check("rst_note_valid", int'(note_valid), 0);
        check("rst_note_idx", int'(note_idx), 0);
        model_reset();
        run(2);
        rst_n = 1'b1;
        for (int k = 0; k < NK; k++) write_tbl(k, tb_vals[k]);

        // Key press latency: beep rises at edge DEB_CYC+3 after the key edge
        key_in = 4'b0001;
        n = 0;
        while (!beep && n < 40) begin
            tick();
            n++;
        end
        check("rise_latency", n, DC + 3);
        run(40);

        // Short glitch on key 1, then one octave up
        key_in = 4'b0011; run(2);
        key_in = 4'b0001; run(20);
        octave = 2'd1;    run(40);

        // Overlapping keys, hand-over, and a silent table entry
        octave = 2'd0;
        key_in = 4'b0110; run(60);
        key_in = 4'b0100; run(40);
        key_in = 4'b1000; run(30);
        check("silent_key3", int'(beep), 0);

        // Release during high and low phases
        key_in = 4'b0001; run(33);
        key_in = 4'b0000; run(30);
        key_in = 4'b0001; run(28);
        key_in = 4'b0000; run(30);

        // Clamp, then table rewrite of the sounding entry
        octave = 2'd3; key_in = 4'b0100; run(30);
        octave = 2'd0; key_in = 4'b0001; run(25);
        write_tbl(0, 16);
        run(60);

        // Randomised key patterns, table writes and octave changes
        for (int seg = 0; seg < 150; seg++) begin
            int dur;
            key_in = 4'($urandom_range(0, 15));
            dur    = $urandom_range(1, 25);
            for (int c = 0; c < dur; c++) begin
                cfg_we   = ($urandom_range(0, 39) == 0);
                cfg_addr = 2'($urandom_range(0, 3));
                cfg_data = CW'($urandom_range(0, 12));
                if ($urandom_range(0, 79) == 0) octave = 2'($urandom_range(0, 3));
                tick();
            end
            cfg_we = 1'b0;
        end

        // Asynchronous reset mid-note, then the cleared table keeps the key silent
        octave = 2'd0;
        key_in = 4'b0000; run(20);
        write_tbl(1, 20);
        key_in = 4'b0010;
        n = 0;
        while (!beep && n < 40) begin
            tick();
            n++;
        end
        check("pre_reset_beep", int'(beep), 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_beep", int'(beep), 0);
        check("async_note_valid", int'(note_valid), 0);
        check("async_note_idx", int'(note_idx), 0);
        run(2);
        rst_n = 1'b1;
        run(30);
        check("post_reset_silent", int'(beep), 0);
        write_tbl(1, 5);
        run(30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
